// File: rtl/hid_pkg.sv
// hid_pkg -- shared definitions for the HID event scheduler.
//   evt_type_e : event type code driven on kbd_mouse_type
//                (0 = mouse X, 1 = mouse Y, 2 = keyboard, 3 never issued)
//   state_e    : scheduler FSM state encoding
//   sat_add8   : signed 8-bit add clamped to -128..127, used when mouse
//                deltas accumulate (HID_SCHED_ACCUM_EN builds)
package hid_pkg;

  typedef enum logic [1:0] {
    MOUSE_X = 2'd0,
    MOUSE_Y = 2'd1,
    KBD     = 2'd2
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    // Overflow shows up as the two top bits of the 9-bit sum disagreeing.
    if (sum[8] != sum[7]) sat_add8 = sum[8] ? 8'h80 : 8'h7F;
    else                  sat_add8 = sum[7:0];
  endfunction

endpackage

// File: rtl/hid_evt_fifo.sv
// hid_evt_fifo -- small synchronous FIFO holding keyboard event bytes.
//   clk, reset_n      : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data   : write request; accepted when not full, or when full
//                       and a pop happens in the same cycle
//   pop, pop_data     : read request; pop_data shows the head (show-ahead)
//   full, empty       : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module hid_evt_fifo
  import hid_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hid_event_sched.sv
// hid_event_sched -- serialises keyboard bytes and mouse X/Y deltas onto a
// single toggle-handshake channel, with a minimum spacing between toggles.
//   clk, reset_n              : clock, asynchronous active-low reset
//   kbd_strobe, kbd_code      : one-cycle keyboard event, queued in a FIFO
//   mouse_strobe, mouse_btn,
//   mouse_dx, mouse_dy        : one-cycle mouse report (dx/dy signed)
//   mouse_buttons             : button state, updated on each mouse X emit
//   kbd_mouse_level           : toggles once per emitted event
//   kbd_mouse_type/data       : event type code and payload, held between emits
//   kbd_overflow              : sticky, a keyboard event was dropped
// Configuration macro HID_SCHED_ACCUM_EN: when defined, pending mouse deltas
// accumulate with signed saturation; otherwise the newest report wins.
module hid_event_sched
  import hid_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int KBD_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       kbd_strobe,
  input  logic [7:0] kbd_code,
  input  logic       mouse_strobe,
  input  logic [2:0] mouse_btn,
  input  logic [7:0] mouse_dx,
  input  logic [7:0] mouse_dy,
  output logic [2:0] mouse_buttons,
  output logic       kbd_mouse_level,
  output logic [1:0] kbd_mouse_type,
  output logic [7:0] kbd_mouse_data,
  output logic       kbd_overflow
);

  localparam int CNT_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kbd_next_q, kbd_next_d;
  logic             level_q, level_d;
  evt_type_e        type_q, type_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       buttons_q, buttons_d;
  logic             overflow_q, overflow_d;
  logic             pend_q, pend_d;
  logic [7:0]       px_q, px_d;
  logic [7:0]       py_q, py_d;
  logic [2:0]       pbtn_q, pbtn_d;
  logic [7:0]       snap_py_q, snap_py_d;

  logic             grant_kbd;
  logic             grant_mouse;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  hid_evt_fifo #(.DEPTH(KBD_DEPTH), .WIDTH(8)) u_kbd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (kbd_strobe),
    .push_data (kbd_code),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scheduler: outputs are loaded on the edge that enters EMIT, so they are
  // visible during the EMIT cycle itself.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kbd_next_d  = kbd_next_q;
    level_d     = level_q;
    type_d      = type_q;
    data_d      = data_q;
    buttons_d   = buttons_q;
    snap_py_d   = snap_py_q;
    grant_kbd   = 1'b0;
    grant_mouse = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || pend_q) begin
          grant_kbd   = !fifo_empty && (!pend_q || kbd_next_q);
          grant_mouse = !grant_kbd;
          state_d     = ST_EMIT;
          level_d     = ~level_q;
          if (grant_kbd) begin
            type_d     = KBD;
            data_d     = fifo_head;
            kbd_next_d = 1'b0;
          end else begin
            type_d     = MOUSE_X;
            data_d     = px_q;
            buttons_d  = pbtn_q;
            snap_py_d  = py_q;
            kbd_next_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        fifo_pop = (type_q == KBD);
        cnt_d    = GAP_LOAD;
        // With the minimum gap the IDLE cycle alone is the whole gap.
        if (GAP_CYCLES == 2 && type_q != MOUSE_X) state_d = ST_IDLE;
        else                                      state_d = ST_GAP;
      end
      ST_GAP: begin
        // type_q still holds MOUSE_X while the Y half of a pair is owed.
        if (type_q == MOUSE_X) begin
          if (cnt_q == '0) begin
            state_d = ST_EMIT;
            level_d = ~level_q;
            type_d  = MOUSE_Y;
            data_d  = snap_py_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          // Leave one count early: the IDLE cycle completes the gap.
          if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Mouse pending state; a grant clears it first so a report arriving in
  // the snapshot cycle starts a fresh accumulation.
  always_comb begin
    pend_d     = pend_q;
    px_d       = px_q;
    py_d       = py_q;
    pbtn_d     = pbtn_q;
    overflow_d = overflow_q | (kbd_strobe & fifo_full & ~fifo_pop);
    if (grant_mouse) begin
      pend_d = 1'b0;
      px_d   = '0;
      py_d   = '0;
    end
    if (mouse_strobe) begin
      pend_d = 1'b1;
      pbtn_d = mouse_btn;
`ifdef HID_SCHED_ACCUM_EN
      px_d   = sat_add8(px_d, mouse_dx);
      py_d   = sat_add8(py_d, mouse_dy);
`else
      px_d   = mouse_dx;
      py_d   = mouse_dy;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      kbd_next_q <= 1'b1;
      level_q    <= 1'b0;
      type_q     <= MOUSE_X;
      data_q     <= '0;
      buttons_q  <= '0;
      overflow_q <= 1'b0;
      pend_q     <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      pbtn_q     <= '0;
      snap_py_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kbd_next_q <= kbd_next_d;
      level_q    <= level_d;
      type_q     <= type_d;
      data_q     <= data_d;
      buttons_q  <= buttons_d;
      overflow_q <= overflow_d;
      pend_q     <= pend_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pbtn_q     <= pbtn_d;
      snap_py_q  <= snap_py_d;
    end
  end

  assign mouse_buttons   = buttons_q;
  assign kbd_mouse_level = level_q;
  assign kbd_mouse_type  = type_q;
  assign kbd_mouse_data  = data_q;
  assign kbd_overflow    = overflow_q;

endmodule

// File: tb/tb_hid_event_sched.sv
// tb_hid_event_sched -- directed bench for hid_event_sched (default params).
// A monitor logs every kbd_mouse_level toggle (cycle, type, data, buttons);
// each scenario task drives strobes and compares the log to a hand-built
// table of expected events, with cycles relative to the first strobe.
module tb_hid_event_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       kbd_strobe = 1'b0;
  logic [7:0] kbd_code = '0;
  logic       mouse_strobe = 1'b0;
  logic [2:0] mouse_btn = '0;
  logic [7:0] mouse_dx = '0;
  logic [7:0] mouse_dy = '0;
  logic [2:0] mouse_buttons;
  logic       kbd_mouse_level;
  logic [1:0] kbd_mouse_type;
  logic [7:0] kbd_mouse_data;
  logic       kbd_overflow;

  hid_event_sched #(.GAP_CYCLES(16), .KBD_DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .kbd_strobe      (kbd_strobe),
    .kbd_code        (kbd_code),
    .mouse_strobe    (mouse_strobe),
    .mouse_btn       (mouse_btn),
    .mouse_dx        (mouse_dx),
    .mouse_dy        (mouse_dy),
    .mouse_buttons   (mouse_buttons),
    .kbd_mouse_level (kbd_mouse_level),
    .kbd_mouse_type  (kbd_mouse_type),
    .kbd_mouse_data  (kbd_mouse_data),
    .kbd_overflow    (kbd_overflow)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int         cyc;
    logic [1:0] typ;
    logic [7:0] data;
    logic [2:0] btn;
  } ev_t;

  ev_t  evq[$];
  logic lvl_prev = 1'b0;

  always @(negedge clk) begin
    if (reset_n && kbd_mouse_level !== lvl_prev)
      evq.push_back('{cycle, kbd_mouse_type, kbd_mouse_data, mouse_buttons});
    lvl_prev = kbd_mouse_level;
  end

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HID_SCHED_ACCUM_EN
  localparam logic [7:0] ACC_X = 8'h7F;
  localparam logic [7:0] ACC_Y = 8'h80;
`else
  localparam logic [7:0] ACC_X = 8'h64;
  localparam logic [7:0] ACC_Y = 8'h9C;
`endif

  // Advance to just after the next rising edge; returns that cycle number.
  task automatic next_cycle(output int c);
    @(posedge clk);
    #1;
    c = cycle;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for the log to reach n entries.
  task automatic wait_events(input int n, input int budget);
    int k;
    k = 0;
    while (evq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_cycles(3);
    n_checks++;
    if ({kbd_mouse_level, kbd_mouse_type, kbd_mouse_data, mouse_buttons, kbd_overflow} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl=%b type=%0d data=%02h btn=%0d ovf=%b, need all 0",
               kbd_mouse_level, kbd_mouse_type, kbd_mouse_data, mouse_buttons, kbd_overflow);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle_cycles(4);
    n_checks++;
    if (evq.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d toggles, need 0", evq.size());
    end
  endtask

  task automatic test_kbd_single();
    int s;
    evq.delete();
    next_cycle(s);
    kbd_strobe = 1'b1; kbd_code = 8'h45;
    #10 kbd_strobe = 1'b0;
    wait_events(1, 20);
    n_checks++;
    if (evq.size() < 1) begin
      n_fail++;
      $display("FAIL kbd_single: got %0d toggles, need 1", evq.size());
    end else if (evq[0].cyc - s !== 2 || evq[0].typ !== 2'd2 || evq[0].data !== 8'h45) begin
      n_fail++;
      $display("FAIL kbd_single: got +%0d type %0d data %02h, need +2 type 2 data 45",
               evq[0].cyc - s, evq[0].typ, evq[0].data);
    end
    idle_cycles(30);
    n_checks++;
    if (evq.size() !== 1 || kbd_mouse_type !== 2'd2 || kbd_mouse_data !== 8'h45) begin
      n_fail++;
      $display("FAIL kbd_hold: got %0d toggles type %0d data %02h, need 1 toggle type 2 data 45",
               evq.size(), kbd_mouse_type, kbd_mouse_data);
    end
  endtask

  task automatic test_mouse_pair();
    int s;
    int         e_cyc[2]  = '{2, 18};
    logic [1:0] e_typ[2]  = '{2'd0, 2'd1};
    logic [7:0] e_data[2] = '{8'h05, 8'hFD};
    evq.delete();
    next_cycle(s);
    mouse_strobe = 1'b1; mouse_btn = 3'b001; mouse_dx = 8'd5; mouse_dy = 8'hFD;
    #10 mouse_strobe = 1'b0;
    wait_events(2, 40);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (evq.size() <= i) begin
        n_fail++;
        $display("FAIL mouse_pair ev%0d: got %0d toggles, need %0d", i, evq.size(), i + 1);
      end else if (evq[i].cyc - s !== e_cyc[i] || evq[i].typ !== e_typ[i] ||
                   evq[i].data !== e_data[i] || evq[i].btn !== 3'b001) begin
        n_fail++;
        $display("FAIL mouse_pair ev%0d: got +%0d type %0d data %02h btn %0d, need +%0d type %0d data %02h btn 1",
                 i, evq[i].cyc - s, evq[i].typ, evq[i].data, evq[i].btn, e_cyc[i], e_typ[i], e_data[i]);
      end
    end
    idle_cycles(30);
    n_checks++;
    if (evq.size() !== 2) begin
      n_fail++;
      $display("FAIL mouse_pair_count: got %0d toggles, need 2", evq.size());
    end
  endtask

  task automatic test_kbd_overflow();
    int s, c;
    evq.delete();
    n_checks++;
    if (kbd_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pre: got %b, need 0", kbd_overflow);
    end
    next_cycle(s);
    kbd_strobe = 1'b1;
    kbd_code = 8'h10;
    for (int i = 1; i < 6; i++) begin
      next_cycle(c);
      kbd_code = 8'h10 + 8'(i);
    end
    next_cycle(c);
    kbd_strobe = 1'b0;
    wait_events(5, 100);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (evq.size() <= i) begin
        n_fail++;
        $display("FAIL kbd_burst ev%0d: got %0d toggles, need %0d", i, evq.size(), i + 1);
      end else if (evq[i].cyc - s !== 2 + 16 * i || evq[i].typ !== 2'd2 ||
                   evq[i].data !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL kbd_burst ev%0d: got +%0d type %0d data %02h, need +%0d type 2 data %02h",
                 i, evq[i].cyc - s, evq[i].typ, evq[i].data, 2 + 16 * i, 8'h10 + 8'(i));
      end
    end
    idle_cycles(40);
    n_checks++;
    if (evq.size() !== 5 || kbd_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL kbd_overflow: got %0d toggles ovf=%b, need 5 toggles ovf=1",
               evq.size(), kbd_overflow);
    end
  endtask

  // Last grant was keyboard, so with both pending the mouse pair goes first.
  task automatic test_round_robin();
    int s;
    int         e_cyc[3]  = '{2, 18, 34};
    logic [1:0] e_typ[3]  = '{2'd0, 2'd1, 2'd2};
    logic [7:0] e_data[3] = '{8'h07, 8'h09, 8'h33};
    evq.delete();
    next_cycle(s);
    kbd_strobe = 1'b1; kbd_code = 8'h33;
    mouse_strobe = 1'b1; mouse_btn = 3'b010; mouse_dx = 8'h07; mouse_dy = 8'h09;
    #10 kbd_strobe = 1'b0; mouse_strobe = 1'b0;
    wait_events(3, 80);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (evq.size() <= i) begin
        n_fail++;
        $display("FAIL round_robin ev%0d: got %0d toggles, need %0d", i, evq.size(), i + 1);
      end else if (evq[i].cyc - s !== e_cyc[i] || evq[i].typ !== e_typ[i] ||
                   evq[i].data !== e_data[i] || evq[i].btn !== 3'b010) begin
        n_fail++;
        $display("FAIL round_robin ev%0d: got +%0d type %0d data %02h btn %0d, need +%0d type %0d data %02h btn 2",
                 i, evq[i].cyc - s, evq[i].typ, evq[i].data, evq[i].btn, e_cyc[i], e_typ[i], e_data[i]);
      end
    end
    idle_cycles(30);
  endtask

  // Two mouse reports arrive while a keyboard event is in its gap.
  task automatic test_accum();
    int s, c;
    int         e_cyc[3]  = '{2, 18, 34};
    logic [1:0] e_typ[3]  = '{2'd2, 2'd0, 2'd1};
    logic [7:0] e_data[3] = '{8'h01, ACC_X, ACC_Y};
    evq.delete();
    next_cycle(s);
    kbd_strobe = 1'b1; kbd_code = 8'h01;
    #10 kbd_strobe = 1'b0;
    for (int r = 0; r < 2; r++) begin
      repeat (2) next_cycle(c);
      mouse_strobe = 1'b1; mouse_btn = 3'b110; mouse_dx = 8'd100; mouse_dy = 8'h9C;
      #10 mouse_strobe = 1'b0;
    end
    wait_events(3, 80);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (evq.size() <= i) begin
        n_fail++;
        $display("FAIL accum ev%0d: got %0d toggles, need %0d", i, evq.size(), i + 1);
      end else if (evq[i].cyc - s !== e_cyc[i] || evq[i].typ !== e_typ[i] || evq[i].data !== e_data[i]) begin
        n_fail++;
        $display("FAIL accum ev%0d: got +%0d type %0d data %02h, need +%0d type %0d data %02h",
                 i, evq[i].cyc - s, evq[i].typ, evq[i].data, e_cyc[i], e_typ[i], e_data[i]);
      end
    end
    n_checks++;
    if (mouse_buttons !== 3'b110) begin
      n_fail++;
      $display("FAIL accum_btn: got %0d, need 6", mouse_buttons);
    end
    idle_cycles(30);
  endtask

  // Second report lands in the snapshot cycle and becomes a new pair.
  task automatic test_snapshot();
    int s, c;
    int         e_cyc[4]  = '{2, 18, 34, 50};
    logic [1:0] e_typ[4]  = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [7:0] e_data[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [2:0] e_btn[4]  = '{3'd1, 3'd1, 3'd4, 3'd4};
    evq.delete();
    next_cycle(s);
    mouse_strobe = 1'b1; mouse_btn = 3'd1; mouse_dx = 8'h01; mouse_dy = 8'h02;
    next_cycle(c);
    mouse_btn = 3'd4; mouse_dx = 8'h03; mouse_dy = 8'h04;
    next_cycle(c);
    mouse_strobe = 1'b0;
    wait_events(4, 100);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (evq.size() <= i) begin
        n_fail++;
        $display("FAIL snapshot ev%0d: got %0d toggles, need %0d", i, evq.size(), i + 1);
      end else if (evq[i].cyc - s !== e_cyc[i] || evq[i].typ !== e_typ[i] ||
                   evq[i].data !== e_data[i] || evq[i].btn !== e_btn[i]) begin
        n_fail++;
        $display("FAIL snapshot ev%0d: got +%0d type %0d data %02h btn %0d, need +%0d type %0d data %02h btn %0d",
                 i, evq[i].cyc - s, evq[i].typ, evq[i].data, evq[i].btn, e_cyc[i], e_typ[i], e_data[i], e_btn[i]);
      end
    end
    idle_cycles(30);
  endtask

  task automatic test_reset_mid_pair();
    int s, c;
    evq.delete();
    next_cycle(s);
    mouse_strobe = 1'b1; mouse_btn = 3'd5; mouse_dx = 8'h11; mouse_dy = 8'h22;
    #10 mouse_strobe = 1'b0;
    wait_events(1, 20);
    n_checks++;
    if (evq.size() !== 1 || evq[0].data !== 8'h11 || evq[0].btn !== 3'd5) begin
      n_fail++;
      $display("FAIL mid_pair_x: got %0d toggles, need 1 with data 11 btn 5", evq.size());
    end
    repeat (4) next_cycle(c);
    reset_n = 1'b0;
    idle_cycles(2);
    n_checks++;
    if ({kbd_mouse_level, kbd_mouse_type, kbd_mouse_data, mouse_buttons, kbd_overflow} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_pair_reset: got lvl=%b type=%0d data=%02h btn=%0d ovf=%b, need all 0",
               kbd_mouse_level, kbd_mouse_type, kbd_mouse_data, mouse_buttons, kbd_overflow);
    end
    next_cycle(c);
    reset_n = 1'b1;
    idle_cycles(40);
    n_checks++;
    if (evq.size() !== 1 || kbd_mouse_level !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pair_no_y: got %0d toggles lvl=%b, need 1 toggle lvl=0",
               evq.size(), kbd_mouse_level);
    end
  endtask

  initial begin
    test_reset();
    test_kbd_single();
    test_mouse_pair();
    test_kbd_overflow();
    test_round_robin();
    test_accum();
    test_snapshot();
    test_reset_mid_pair();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
